// File: rtl/bcd_to_binary_seq.sv
`default_nettype none
// ============================================================================
// bcd_to_binary_seq : 3-digit BCD to binary, reverse double-dabble, 1 bit/clk
// Rev 1.0
// ============================================================================
module bcd_to_binary_seq #(
  parameter int BIN_W = 8
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       hundreds,
  input  logic [3:0]       tens,
  input  logic [3:0]       ones,
  output logic             busy,
  output logic             done,
  output logic [BIN_W-1:0] bin,
  output logic             ovf,
  output logic             err
);

  localparam int CNT_W = 4;
  localparam int BCD_W = 10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [BCD_W-1:0] bcd_q,   bcd_d;
  logic [BIN_W-1:0] acc_q,   acc_d;
  logic [BIN_W-1:0] bin_q,   bin_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic             ovf_q,   ovf_d;
  logic             err_q,   err_d;

  logic             digits_valid;
  logic [BCD_W-1:0] bcd_shr;
  logic [BIN_W-1:0] acc_shr;
  logic [3:0]       tens_adj;
  logic [3:0]       ones_adj;
  logic [BCD_W-1:0] bcd_next;
  logic             last_iter;

  assign digits_valid = (hundreds != 2'd3) && (tens <= 4'd9) && (ones <= 4'd9);

  // Low bit of the ones nibble falls into the top of the binary field.
  assign bcd_shr   = bcd_q >> 1;
  assign acc_shr   = {bcd_q[0], acc_q[BIN_W-1:1]};
  assign tens_adj  = (bcd_shr[7:4] >= 4'd8) ? (bcd_shr[7:4] - 4'd3) : bcd_shr[7:4];
  assign ones_adj  = (bcd_shr[3:0] >= 4'd8) ? (bcd_shr[3:0] - 4'd3) : bcd_shr[3:0];
  assign bcd_next  = {bcd_shr[9:8], tens_adj, ones_adj};
  assign last_iter = (cnt_q == CNT_W'(BIN_W - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    acc_d   = acc_q;
    bin_d   = bin_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!digits_valid) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
            ovf_d   = 1'b0;
            bin_d   = '0;
          end else begin
            state_d = S_SHIFT;
            bcd_d   = {hundreds, tens, ones};
            acc_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            err_d   = 1'b0;
            ovf_d   = 1'b0;
          end
        end
      end

      S_SHIFT: begin
        bcd_d = bcd_next;
        acc_d = acc_shr;
        cnt_d = cnt_q + 1'b1;
        if (last_iter) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          bin_d   = acc_shr;
          // Any value left in the BCD field did not fit in BIN_W bits.
          ovf_d   = (bcd_next != '0);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bcd_q   <= '0;
      acc_q   <= '0;
      bin_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      acc_q   <= acc_d;
      bin_q   <= bin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bin  = bin_q;
  assign ovf  = ovf_q;
  assign err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_binary_seq.sv
`default_nettype none
// ============================================================================
// tb_bcd_to_binary_seq : scoreboard bench, BIN_W=8 and BIN_W=9 instances
// Rev 1.0
// ============================================================================
module tb_bcd_to_binary_seq;

  typedef struct packed {
    logic [9:0] bin;
    logic       ovf;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       start9;
  logic [1:0] h;
  logic [3:0] t;
  logic [3:0] o;

  logic       busy8, done8, ovf8, err8;
  logic [7:0] bin8;
  logic       busy9, done9, ovf9, err9;
  logic [8:0] bin9;

  exp_t q8[$];
  exp_t q9[$];
  exp_t e8, e9;
  logic prev_done8 = 1'b0;
  logic prev_done9 = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   c1, c2;

  always #5 clk = ~clk;

  bcd_to_binary_seq #(.BIN_W(8)) u_dut8 (
    .CLOCK_50(clk), .reset_n(rst_n), .start(start),
    .hundreds(h), .tens(t), .ones(o),
    .busy(busy8), .done(done8), .bin(bin8), .ovf(ovf8), .err(err8)
  );

  bcd_to_binary_seq #(.BIN_W(9)) u_dut9 (
    .CLOCK_50(clk), .reset_n(rst_n), .start(start9),
    .hundreds(h), .tens(t), .ones(o),
    .busy(busy9), .done(done9), .bin(bin9), .ovf(ovf9), .err(err9)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input int w, input logic [1:0] hh,
                                 input logic [3:0] tt, input logic [3:0] oo);
    exp_t e;
    int   v;
    e = '0;
    if (hh == 2'd3 || tt > 4'd9 || oo > 4'd9) begin
      e.err = 1'b1;
      return e;
    end
    v     = int'(hh) * 100 + int'(tt) * 10 + int'(oo);
    e.bin = 10'(v % (1 << w));
    e.ovf = (v >= (1 << w));
    return e;
  endfunction

  // Scoreboard: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done8) begin
      check("done8_width", {31'd0, prev_done8}, 32'd0);
      if (q8.size() == 0) begin
        check("done8_unexpected", 32'd1, 32'd0);
      end else begin
        e8 = q8.pop_front();
        check("bin8", {24'd0, bin8}, {22'd0, e8.bin});
        check("ovf8", {31'd0, ovf8}, {31'd0, e8.ovf});
        check("err8", {31'd0, err8}, {31'd0, e8.err});
        check("busy8_at_done", {31'd0, busy8}, 32'd0);
      end
    end
    if (rst_n === 1'b1 && done9) begin
      if (q9.size() == 0) begin
        check("done9_unexpected", 32'd1, 32'd0);
      end else begin
        e9 = q9.pop_front();
        check("bin9", {23'd0, bin9}, {22'd0, e9.bin});
        check("ovf9", {31'd0, ovf9}, {31'd0, e9.ovf});
        check("err9", {31'd0, err9}, {31'd0, e9.err});
      end
    end
    prev_done8 <= done8;
    prev_done9 <= done9;
  end

  task automatic wait_done(input bit sel9, output int cyc);
    cyc = 0;
    while (!(sel9 ? done9 : done8) && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 40) check("done_timeout", 32'd1, 32'd0);
  endtask

  task automatic run(input bit sel9, input logic [1:0] hh,
                     input logic [3:0] tt, input logic [3:0] oo);
    exp_t e;
    int   cyc;
    int   nbusy;
    int   w;
    w = sel9 ? 9 : 8;
    @(negedge clk);
    h = hh; t = tt; o = oo;
    e = model(w, hh, tt, oo);
    if (sel9) begin q9.push_back(e); start9 = 1'b1; end
    else      begin q8.push_back(e); start  = 1'b1; end
    @(negedge clk);
    start = 1'b0; start9 = 1'b0;
    cyc = 0; nbusy = 0;
    while (!(sel9 ? done9 : done8) && cyc < 40) begin
      if (sel9 ? busy9 : busy8) nbusy++;
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, e.err ? 0 : w);
    check("busy_cycles", nbusy, e.err ? 0 : w);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; start9 = 1'b0;
    h = 2'd0; t = 4'd0; o = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy8}, 32'd0);
    check("rst_done", {31'd0, done8}, 32'd0);
    check("rst_bin",  {24'd0, bin8},  32'd0);
    check("rst_ovf",  {31'd0, ovf8},  32'd0);
    check("rst_err",  {31'd0, err8},  32'd0);
    rst_n = 1'b1;

    run(1'b0, 2'd2, 4'd5, 4'd5);
    run(1'b0, 2'd0, 4'd0, 4'd0);
    run(1'b0, 2'd1, 4'd2, 4'd8);
    run(1'b0, 2'd0, 4'd9, 4'd9);
    run(1'b0, 2'd2, 4'd9, 4'd9);
    run(1'b1, 2'd2, 4'd9, 4'd9);
    run(1'b0, 2'd1, 4'd10, 4'd3);
    run(1'b0, 2'd3, 4'd0, 4'd0);

    // Start and input changes while a conversion is in flight are ignored.
    @(negedge clk);
    h = 2'd1; t = 4'd0; o = 4'd0; start = 1'b1;
    q8.push_back(model(8, 2'd1, 4'd0, 4'd0));
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    h = 2'd2; t = 4'd7; o = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0; t = 4'd9;
    wait_done(1'b0, c1);
    repeat (12) @(negedge clk);
    check("midconv_drained", q8.size(), 32'd0);

    // start held high: two conversions BIN_W+2 cycles apart.
    @(negedge clk);
    h = 2'd0; t = 4'd1; o = 4'd7; start = 1'b1;
    q8.push_back(model(8, 2'd0, 4'd1, 4'd7));
    q8.push_back(model(8, 2'd0, 4'd1, 4'd7));
    wait_done(1'b0, c1);
    @(negedge clk);
    wait_done(1'b0, c2);
    start = 1'b0;
    check("b2b_spacing", c2 + 1, 32'd10);
    repeat (14) @(negedge clk);
    check("b2b_drained", q8.size(), 32'd0);

    // Reset mid-conversion discards the result.
    @(negedge clk);
    h = 2'd1; t = 4'd0; o = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_busy", {31'd0, busy8}, 32'd0);
    check("midrst_done", {31'd0, done8}, 32'd0);
    check("midrst_bin",  {24'd0, bin8},  32'd0);
    check("midrst_ovf",  {31'd0, ovf8},  32'd0);
    check("midrst_err",  {31'd0, err8},  32'd0);
    repeat (14) @(negedge clk);
    run(1'b0, 2'd0, 4'd4, 4'd2);

    repeat (3) @(negedge clk);
    check("q8_empty", q8.size(), 32'd0);
    check("q9_empty", q9.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
